// File: rtl/rr_arbiter_param.sv
// rr_arbiter_param: work-conserving round-robin arbiter with packet hold
// and an optional hold limit. The one-hot grant, its binary index and the
// hold counter are all registered, so no request or enable input reaches
// an output without passing through a flop.

module rr_arbiter_param #(
    parameter  int N        = 32,
    parameter  int MAX_HOLD = 8,
    localparam int IDXW     = $clog2(N),
    localparam int HCW      = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    enabled,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    ack,
    output logic            ack_valid,
    output logic [IDXW-1:0] ack_idx,
    output logic [HCW-1:0]  hold_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Value at which hold_cnt stops counting. With no hold limit the
    // counter is a single bit, so it sticks at 1.
    localparam logic [HCW-1:0] HOLD_SAT = HCW'((MAX_HOLD == 0) ? 1 : MAX_HOLD);

    state_t          state_q, state_d;
    logic [N-1:0]    ack_q, ack_d;
    logic            ackValid_q, ackValid_d;
    logic [IDXW-1:0] ackIdx_q, ackIdx_d;
    logic [HCW-1:0]  holdCnt_q, holdCnt_d;
    logic [IDXW-1:0] ptr_q, ptr_d;

    logic [N-1:0]    elig;
    logic [N-1:0]    cand;
    logic            othersElig;
    logic            terminate;
    logic            found;
    logic [IDXW-1:0] selIdx;
    logic [IDXW-1:0] posIdx;
    logic [IDXW-1:0] nextPtr;
    int              pos;

    // The current owner is masked out of the candidates. In IDLE ack_q is
    // zero, so the same candidate vector serves both first grants and
    // back-to-back handovers.
    assign elig       = req & enabled;
    assign cand       = elig & ~ack_q;
    assign othersElig = |cand;

    // Cyclic first-set search over the candidates starting at ptr_q. After
    // a grant to g the pointer already sits at g+1, so a handover search
    // needs no separate start index.
    always_comb begin
        found  = 1'b0;
        selIdx = '0;
        pos    = 0;
        posIdx = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            posIdx = IDXW'(pos);
            if (!found && cand[posIdx]) begin
                found  = 1'b1;
                selIdx = posIdx;
            end
        end
    end

    // Pointer following a grant to selIdx, wrapping N-1 to 0 for any N.
    always_comb begin
        nextPtr = (selIdx == IDXW'(N - 1)) ? '0 : selIdx + 1'b1;
    end

    // The owner loses the grant when it drops its request, is disabled, or
    // has used up its hold budget while someone else is waiting. The limit
    // uses >= so an owner that saturated while alone still yields once a
    // competitor shows up.
    always_comb begin
        terminate = 1'b0;
        if (!req[ackIdx_q] || !enabled[ackIdx_q]) begin
            terminate = 1'b1;
        end else if ((MAX_HOLD != 0) && (int'(holdCnt_q) >= MAX_HOLD - 1) && othersElig) begin
            terminate = 1'b1;
        end
    end

    // Next-state logic: issue a new grant from IDLE or on owner termination,
    // otherwise keep the owner and advance its saturating hold counter.
    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        ackValid_d = ackValid_q;
        ackIdx_d   = ackIdx_q;
        holdCnt_d  = holdCnt_q;
        ptr_d      = ptr_q;

        if ((state_q == IDLE) || terminate) begin
            if (found) begin
                state_d    = GRANT;
                ack_d      = {{(N-1){1'b0}}, 1'b1} << selIdx;
                ackValid_d = 1'b1;
                ackIdx_d   = selIdx;
                holdCnt_d  = '0;
                ptr_d      = nextPtr;
            end else begin
                state_d    = IDLE;
                ack_d      = '0;
                ackValid_d = 1'b0;
                holdCnt_d  = '0;
            end
        end else begin
            if (holdCnt_q != HOLD_SAT) begin
                holdCnt_d = holdCnt_q + 1'b1;
            end
        end
    end

    // State and output registers; reset clears everything at once, even
    // in the middle of a grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ack_q      <= '0;
            ackValid_q <= 1'b0;
            ackIdx_q   <= '0;
            holdCnt_q  <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            ackValid_q <= ackValid_d;
            ackIdx_q   <= ackIdx_d;
            holdCnt_q  <= holdCnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign ack       = ack_q;
    assign ack_valid = ackValid_q;
    assign ack_idx   = ackIdx_q;
    assign hold_cnt  = holdCnt_q;

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Directed bench for rr_arbiter_param. Four instances cover the sizes and
// hold limits of interest; each expected value is worked out by hand from
// the arbitration rules.

module tb_rr_arbiter_param;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    int vectorsApplied = 0;
    int miscompares    = 0;

    // N=4, no hold limit
    logic [3:0] enA, reqA, ackA;
    logic       valA;
    logic [1:0] idxA;
    logic [0:0] holdA;
    // N=4, hold limit 4
    logic [3:0] enB, reqB, ackB;
    logic       valB;
    logic [1:0] idxB;
    logic [2:0] holdB;
    // N=32, default hold limit 8
    logic [31:0] enC, reqC, ackC;
    logic        valC;
    logic [4:0]  idxC;
    logic [3:0]  holdC;
    // N=5, no hold limit
    logic [4:0] enD, reqD, ackD;
    logic       valD;
    logic [2:0] idxD;
    logic [0:0] holdD;

    rr_arbiter_param #(.N(4), .MAX_HOLD(0)) uA (
        .clk(clk), .reset_n(reset_n), .enabled(enA), .req(reqA),
        .ack(ackA), .ack_valid(valA), .ack_idx(idxA), .hold_cnt(holdA));

    rr_arbiter_param #(.N(4), .MAX_HOLD(4)) uB (
        .clk(clk), .reset_n(reset_n), .enabled(enB), .req(reqB),
        .ack(ackB), .ack_valid(valB), .ack_idx(idxB), .hold_cnt(holdB));

    rr_arbiter_param #(.N(32), .MAX_HOLD(8)) uC (
        .clk(clk), .reset_n(reset_n), .enabled(enC), .req(reqC),
        .ack(ackC), .ack_valid(valC), .ack_idx(idxC), .hold_cnt(holdC));

    rr_arbiter_param #(.N(5), .MAX_HOLD(0)) uD (
        .clk(clk), .reset_n(reset_n), .enabled(enD), .req(reqD),
        .ack(ackD), .ack_valid(valD), .ack_idx(idxD), .hold_cnt(holdD));

    // Single comparison point: counts the vector and reports a miscompare.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Reset all instances with their request lines cleared.
    task automatic resetAll();
        reqA = '0; reqB = '0; reqC = '0; reqD = '0;
        reset_n = 1'b0;
        applyStimulus();
        applyStimulus();
        reset_n = 1'b1;
    endtask

    initial begin
        enA = 4'hF; enB = 4'hF; enC = '1; enD = 5'h1F;
        reqA = '0; reqB = '0; reqC = '0; reqD = '0;
        $display("[TB] start");

        resetAll();
        checkOutput("rst_ackA", 64'(ackA), 64'h0);
        checkOutput("rst_valA", 64'(valA), 64'h0);
        checkOutput("rst_idxB", 64'(idxB), 64'h0);
        checkOutput("rst_holdB", 64'(holdB), 64'h0);
        checkOutput("rst_ackC", 64'(ackC), 64'h0);

        // Packet hold then handover with no gap (N=4, unlimited hold)
        reqA = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            checkOutput($sformatf("t1_ack%0d", c), 64'(ackA), 64'h2);
            checkOutput($sformatf("t1_idx%0d", c), 64'(idxA), 64'h1);
        end
        reqA = 4'b1000;
        applyStimulus();
        checkOutput("t1_ackNext", 64'(ackA), 64'h8);
        checkOutput("t1_idxNext", 64'(idxA), 64'h3);
        checkOutput("t1_valNext", 64'(valA), 64'h1);

        // Hold limit rotation: each owner exactly 4 cycles, order 0,1,2,3,0
        resetAll();
        reqB = 4'hF;
        for (int c = 0; c < 17; c++) begin
            applyStimulus();
            checkOutput($sformatf("t2_idx%0d", c), 64'(idxB), 64'((c / 4) % 4));
            checkOutput($sformatf("t2_ack%0d", c), 64'(ackB), 64'(1) << ((c / 4) % 4));
            checkOutput($sformatf("t2_hold%0d", c), 64'(holdB), 64'(c % 4));
        end

        // Lone requester keeps the grant and hold_cnt saturates at 4
        resetAll();
        reqB = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            applyStimulus();
            checkOutput($sformatf("t3_ack%0d", c), 64'(ackB), 64'h4);
            checkOutput($sformatf("t3_hold%0d", c), 64'(holdB), 64'((c < 4) ? c : 4));
        end
        // A competitor arriving after saturation takes over on the next edge
        reqB = 4'b0101;
        applyStimulus();
        checkOutput("t3_yield", 64'(ackB), 64'h1);

        // Disabled requesters are never granted (N=32)
        resetAll();
        enC  = 32'hF0FF_FFF0;
        reqC = 32'h0000_000F;
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            checkOutput($sformatf("t4_ack%0d", c), 64'(ackC), 64'h0);
            checkOutput($sformatf("t4_val%0d", c), 64'(valC), 64'h0);
        end
        enC = 32'hF0FF_FFF2;
        applyStimulus();
        checkOutput("t4_ackEn", 64'(ackC), 64'h2);
        checkOutput("t4_idxEn", 64'(idxC), 64'h1);
        checkOutput("t4_valEn", 64'(valC), 64'h1);
        // Dropping the enable mid-grant revokes it at the next edge
        enC = 32'hF0FF_FFF0;
        applyStimulus();
        checkOutput("t4_revoke", 64'(ackC), 64'h0);

        // Non-power-of-two wrap (N=5)
        resetAll();
        reqD = 5'b10000;
        applyStimulus();
        checkOutput("t5_own4", 64'(ackD), 64'h10);
        reqD = 5'b00011;
        applyStimulus();
        checkOutput("t5_wrapAck", 64'(ackD), 64'h01);
        checkOutput("t5_wrapIdx", 64'(idxD), 64'h0);
        reqD = 5'b00010;
        applyStimulus();
        checkOutput("t5_next", 64'(idxD), 64'h1);

        // Asynchronous reset mid-grant, then search restarts at index 0
        resetAll();
        reqA = 4'b0100;
        applyStimulus();
        checkOutput("t6_pre", 64'(ackA), 64'h4);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_asyncAck", 64'(ackA), 64'h0);
        checkOutput("t6_asyncVal", 64'(valA), 64'h0);
        checkOutput("t6_asyncIdx", 64'(idxA), 64'h0);
        reqA = 4'b0110;
        applyStimulus();
        reset_n = 1'b1;
        applyStimulus();
        checkOutput("t6_firstAck", 64'(ackA), 64'h2);
        checkOutput("t6_firstIdx", 64'(idxA), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
